// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the fractional baud increment.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_t;

   // round(baud*os*2^w/clk), evaluated at elaboration in 64-bit arithmetic
   function automatic longint unsigned baud_inc(input longint unsigned clk,
                                                input longint unsigned baud,
                                                input longint unsigned os,
                                                input int unsigned     w);
      longint unsigned num;
      num = (baud * os) << w;
      return (num + clk / 2) / clk;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional-N oversampling tick generator: the carry out of a phase accumulator
// yields Baud*Oversampling ticks per second on average, never more than one per clk.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned ClkFrequency = 12000000,
   parameter int unsigned Baud         = 2000000,
   parameter int unsigned Oversampling = 4,
   parameter int unsigned AccWidth     = 16
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam longint unsigned IncFull =
      baud_inc(64'(ClkFrequency), 64'(Baud), 64'(Oversampling), AccWidth);
   localparam logic [AccWidth:0] Inc = (AccWidth + 1)'(IncFull);

   logic [AccWidth:0] acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else begin
         acc <= {1'b0, acc[AccWidth-1:0]} + Inc;
      end
   end

   assign tick = acc[AccWidth];

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART byte receiver: synchronises and majority-filters rx, decodes 8N1 frames,
// and reports framing errors, line idle and end of packet.
module uart_rx_oversample
   import uart_pkg::*;
#(
   parameter int unsigned ClkFrequency = 12000000,
   parameter int unsigned Baud         = 2000000,
   parameter int unsigned Oversampling = 4,
   parameter int unsigned AccWidth     = 16,
   parameter int unsigned GapBits      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] RxD_data,
   output logic       RxD_data_ready,
   output logic       RxD_framing_err,
   output logic       RxD_idle,
   output logic       RxD_endofpacket
);

   localparam int unsigned GapMax = GapBits * Oversampling;
   localparam int PhaseW = $clog2(Oversampling);
   localparam int GapW   = $clog2(GapMax + 1);
   localparam logic [PhaseW-1:0] HalfLast = PhaseW'(Oversampling / 2 - 1);
   localparam logic [PhaseW-1:0] BitLast  = PhaseW'(Oversampling - 1);
   localparam logic [GapW-1:0]   GapSat   = GapW'(GapMax);

   if (Oversampling < 4 || Oversampling % 2 != 0) begin : g_bad_oversampling
      $error("uart_rx_oversample: Oversampling must be >= 4 and even");
   end
   if (64'(ClkFrequency) < 64'(Baud) * 64'(Oversampling)) begin : g_bad_clock
      $error("uart_rx_oversample: ClkFrequency must be >= Baud*Oversampling");
   end

   logic              tick;
   logic [1:0]        sync;
   logic [2:0]        hist;
   logic              rx_bit;
   uart_state_t       state;
   logic [PhaseW-1:0] phase;
   logic [2:0]        bitcnt;
   logic [7:0]        shreg;
   logic [GapW-1:0]   gap_cnt;
   logic              pending;

   uart_baud_tick #(
      .ClkFrequency(ClkFrequency),
      .Baud(Baud),
      .Oversampling(Oversampling),
      .AccWidth(AccWidth)
   ) u_baud_tick (
      .clk(clk),
      .rst(rst),
      .tick(tick)
   );

   // Synchroniser and filter reset to the idle (high) line level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
         hist <= 3'b111;
      end else begin
         sync <= {sync[0], rx};
         if (tick) begin
            hist <= {hist[1:0], sync[1]};
         end
      end
   end

   assign rx_bit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         phase           <= '0;
         bitcnt          <= '0;
         shreg           <= '0;
         gap_cnt         <= GapSat;
         pending         <= 1'b0;
         RxD_data        <= '0;
         RxD_data_ready  <= 1'b0;
         RxD_framing_err <= 1'b0;
         RxD_idle        <= 1'b1;
         RxD_endofpacket <= 1'b0;
      end else begin
         RxD_data_ready  <= 1'b0;
         RxD_framing_err <= 1'b0;
         RxD_endofpacket <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (!rx_bit) begin
                     state    <= START;
                     phase    <= '0;
                     gap_cnt  <= '0;
                     RxD_idle <= 1'b0;
                  end else if (gap_cnt != GapSat) begin
                     gap_cnt <= gap_cnt + 1'b1;
                     if (gap_cnt == GapSat - 1'b1) begin
                        RxD_idle <= 1'b1;
                        if (pending) begin
                           RxD_endofpacket <= 1'b1;
                           pending         <= 1'b0;
                        end
                     end
                  end
               end
               // A start bit that is gone by mid-bit was a glitch
               START: begin
                  if (phase == HalfLast) begin
                     phase  <= '0;
                     bitcnt <= '0;
                     state  <= rx_bit ? IDLE : DATA;
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
               DATA: begin
                  if (phase == BitLast) begin
                     phase <= '0;
                     shreg <= {rx_bit, shreg[7:1]};
                     if (bitcnt == 3'd7) begin
                        state <= STOP;
                     end else begin
                        bitcnt <= bitcnt + 1'b1;
                     end
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
               STOP: begin
                  if (phase == BitLast) begin
                     phase <= '0;
                     if (rx_bit) begin
                        RxD_data       <= shreg;
                        RxD_data_ready <= 1'b1;
                        pending        <= 1'b1;
                        state          <= IDLE;
                     end else begin
                        RxD_framing_err <= 1'b1;
                        state           <= WAIT_HIGH;
                     end
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
               WAIT_HIGH: begin
                  if (rx_bit) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench: table-driven frames and corner sequences on a 16 clk/bit receiver,
// plus random bytes on a 6 clk/bit receiver checked against an expected-byte queue.
module tb_uart_rx_oversample;

   localparam int BitClksA = 16;
   localparam int BitClksB = 6;
   localparam int GapClksA = 32;

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      int         brk_clks;
      int         idle_clks;
      logic       check;
      int         exp_rdy;
      int         exp_ferr;
      int         exp_eop;
      logic [7:0] exp_data;
   } vec_t;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       rdy_a, ferr_a, idle_a, eop_a;
   logic       rdy_b, ferr_b, idle_b, eop_b;

   int n_compared   = 0;
   int n_mismatched = 0;
   int cycle        = 0;
   int rdy_cnt_a = 0, ferr_cnt_a = 0, eop_cnt_a = 0, idle_low_a = 0;
   int last_rdy_a = 0, eop_gap_a = 0;
   int rdy_cnt_b = 0, ferr_cnt_b = 0;
   int s_rdy, s_ferr, s_eop, s_idle;
   logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
   logic [7:0] partial;
   logic [7:0] rnd_byte;
   vec_t vecs[6];

   uart_rx_oversample #(
      .ClkFrequency(16000000), .Baud(1000000), .Oversampling(8), .AccWidth(16), .GapBits(2)
   ) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a),
      .RxD_data(data_a), .RxD_data_ready(rdy_a), .RxD_framing_err(ferr_a),
      .RxD_idle(idle_a), .RxD_endofpacket(eop_a)
   );

   uart_rx_oversample #(
      .ClkFrequency(12000000), .Baud(2000000), .Oversampling(4), .AccWidth(16), .GapBits(2)
   ) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b),
      .RxD_data(data_b), .RxD_data_ready(rdy_b), .RxD_framing_err(ferr_b),
      .RxD_idle(idle_b), .RxD_endofpacket(eop_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (rdy_a) begin
         got_a.push_back(data_a);
         rdy_cnt_a++;
         last_rdy_a = cycle;
      end
      if (ferr_a) ferr_cnt_a++;
      if (eop_a) begin
         eop_cnt_a++;
         eop_gap_a = cycle - last_rdy_a;
      end
      if (!idle_a) idle_low_a++;
      if (rdy_b) begin
         got_b.push_back(data_b);
         rdy_cnt_b++;
      end
      if (ferr_b) ferr_cnt_b++;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_compared++;
      if (actual != expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
      end
   endtask

   task automatic checkWindow(input string name, input int actual, input int lo, input int hi);
      n_compared++;
      if (actual < lo || actual > hi) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic driveLine(input int port, input logic val, input int nclk);
      if (port == 0) rx_a = val;
      else           rx_b = val;
      repeat (nclk) @(negedge clk);
   endtask

   task automatic applyStimulus(input int port, input logic [7:0] data, input logic stop_ok,
                                input int brk_clks);
      int bit_clks;
      bit_clks = (port == 0) ? BitClksA : BitClksB;
      driveLine(port, 1'b0, bit_clks);
      for (int i = 0; i < 8; i++) driveLine(port, data[i], bit_clks);
      driveLine(port, stop_ok, bit_clks);
      driveLine(port, 1'b0, brk_clks);
      driveLine(port, 1'b1, 0);
   endtask

   task automatic snapshot();
      s_rdy  = rdy_cnt_a;
      s_ferr = ferr_cnt_a;
      s_eop  = eop_cnt_a;
      s_idle = idle_low_a;
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 0,             64, 1'b1, 1, 0, 1, 8'hA5};
      vecs[1] = '{8'h01, 1'b1, 0,             0,  1'b0, 0, 0, 0, 8'h00};
      vecs[2] = '{8'hFE, 1'b1, 0,             0,  1'b0, 0, 0, 0, 8'h00};
      vecs[3] = '{8'h00, 1'b1, 0,             64, 1'b1, 3, 0, 1, 8'h00};
      vecs[4] = '{8'h55, 1'b0, 20 * BitClksA, 64, 1'b1, 0, 1, 0, 8'h00};
      vecs[5] = '{8'h3C, 1'b1, 0,             64, 1'b1, 1, 0, 1, 8'h3C};

      repeat (4) @(negedge clk);
      checkOutput("reset RxD_data", data_a, 0);
      checkOutput("reset RxD_data_ready", rdy_a, 0);
      checkOutput("reset RxD_framing_err", ferr_a, 0);
      checkOutput("reset RxD_idle", idle_a, 1);
      checkOutput("reset RxD_endofpacket", eop_a, 0);
      rst = 1'b0;
      driveLine(0, 1'b1, 40);
      checkOutput("idle after reset, no endofpacket", eop_cnt_a, 0);

      snapshot();
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].stop_ok) exp_a.push_back(vecs[i].data);
         applyStimulus(0, vecs[i].data, vecs[i].stop_ok, vecs[i].brk_clks);
         driveLine(0, 1'b1, vecs[i].idle_clks);
         if (vecs[i].check) begin
            checkOutput($sformatf("row%0d data_ready count", i), rdy_cnt_a - s_rdy, vecs[i].exp_rdy);
            checkOutput($sformatf("row%0d framing_err count", i), ferr_cnt_a - s_ferr, vecs[i].exp_ferr);
            checkOutput($sformatf("row%0d endofpacket count", i), eop_cnt_a - s_eop, vecs[i].exp_eop);
            checkOutput($sformatf("row%0d RxD_data", i), data_a, vecs[i].exp_data);
            checkOutput($sformatf("row%0d idle dropped in frame", i), int'(idle_low_a > s_idle), 1);
            checkOutput($sformatf("row%0d idle after gap", i), idle_a, 1);
            if (vecs[i].exp_eop != 0)
               checkWindow($sformatf("row%0d eop delay", i), eop_gap_a, GapClksA - 2, GapClksA + 2);
            snapshot();
         end
      end

      // Short low glitch on an idle line
      snapshot();
      driveLine(0, 1'b0, 4);
      driveLine(0, 1'b1, 80);
      checkOutput("glitch data_ready count", rdy_cnt_a - s_rdy, 0);
      checkOutput("glitch framing_err count", ferr_cnt_a - s_ferr, 0);
      checkOutput("glitch endofpacket count", eop_cnt_a - s_eop, 0);
      checkOutput("glitch RxD_data", data_a, 8'h3C);
      checkOutput("glitch idle after", idle_a, 1);

      // Reset in the middle of a byte
      snapshot();
      partial = 8'hF0;
      driveLine(0, 1'b0, BitClksA);
      for (int i = 0; i < 4; i++) driveLine(0, partial[i], BitClksA);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("midreset RxD_data", data_a, 0);
      checkOutput("midreset RxD_idle", idle_a, 1);
      checkOutput("midreset RxD_data_ready", rdy_a, 0);
      checkOutput("midreset RxD_framing_err", ferr_a, 0);
      checkOutput("midreset RxD_endofpacket", eop_a, 0);
      rx_a = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      driveLine(0, 1'b1, 100);
      checkOutput("post-reset data_ready count", rdy_cnt_a - s_rdy, 0);
      checkOutput("post-reset framing_err count", ferr_cnt_a - s_ferr, 0);
      checkOutput("post-reset endofpacket count", eop_cnt_a - s_eop, 0);
      checkOutput("post-reset RxD_data", data_a, 0);
      snapshot();
      exp_a.push_back(8'hC3);
      applyStimulus(0, 8'hC3, 1'b1, 0);
      driveLine(0, 1'b1, 64);
      checkOutput("C3 data_ready count", rdy_cnt_a - s_rdy, 1);
      checkOutput("C3 RxD_data", data_a, 8'hC3);
      checkOutput("C3 endofpacket count", eop_cnt_a - s_eop, 1);
      checkWindow("C3 eop delay", eop_gap_a, GapClksA - 2, GapClksA + 2);

      checkOutput("A byte count", got_a.size(), exp_a.size());
      for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
         checkOutput($sformatf("A byte %0d order", i), got_a[i], exp_a[i]);

      // Random bytes at 12 MHz / 2 Mbaud / x4
      for (int i = 0; i < 100; i++) begin
         rnd_byte = 8'($urandom_range(0, 255));
         exp_b.push_back(rnd_byte);
         applyStimulus(1, rnd_byte, 1'b1, 0);
         driveLine(1, 1'b1, int'($urandom_range(0, 4)));
      end
      driveLine(1, 1'b1, 40);
      checkOutput("B byte count", got_b.size(), exp_b.size());
      checkOutput("B framing_err count", ferr_cnt_b, 0);
      for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
         checkOutput($sformatf("B byte %0d", i), got_b[i], exp_b[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
